// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin data-memory arbiter (core vs host) with hold limit.
// Define DMEM_ARB_HOST_PRIO_EN to give the host fixed priority instead.
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        CORE,
        HOST
    } state_t;

    state_t        state, state_nxt;
    logic          last_host, last_host_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          sel_core, sel_host;
    logic          core_rd, host_rd;

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state     <= IDLE;
            last_host <= 1'b1;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            last_host <= last_host_nxt;
            hold_cnt  <= hold_nxt;
        end
    end

    always_comb begin
        sel_core = 1'b0;
        sel_host = 1'b0;
`ifdef DMEM_ARB_HOST_PRIO_EN
        sel_host = host_req;
        sel_core = core_req & ~host_req;
`else
        unique case (state)
            CORE: begin
                if (core_req && (!host_req || hold_cnt < HOLD_LIM))
                    sel_core = 1'b1;
                else
                    sel_host = host_req;
            end
            HOST: begin
                if (host_req && (!core_req || hold_cnt < HOLD_LIM))
                    sel_host = 1'b1;
                else
                    sel_core = core_req;
            end
            default: begin
                if (core_req && host_req) begin
                    sel_core = last_host;
                    sel_host = ~last_host;
                end else begin
                    sel_core = core_req;
                    sel_host = host_req;
                end
            end
        endcase
`endif
        state_nxt = sel_core ? CORE : (sel_host ? HOST : IDLE);
        last_host_nxt = sel_host ? 1'b1 : (sel_core ? 1'b0 : last_host);
        hold_nxt = '0;
`ifndef DMEM_ARB_HOST_PRIO_EN
        // Counter tracks repeat grants; it saturates so a late waiter still
        // gets through once the owner has used up its window.
        if ((sel_core && state == CORE) || (sel_host && state == HOST))
            hold_nxt = (hold_cnt == HOLD_LIM) ? hold_cnt : hold_cnt + HW'(1);
`endif
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (sel_core) begin
            mem_addr  = core_addr;
            mem_we    = core_we;
            mem_wdata = core_wdata;
        end else if (sel_host) begin
            mem_addr  = host_addr;
            mem_we    = host_we;
            mem_wdata = host_wdata;
        end
    end

    assign core_gnt   = sel_core;
    assign host_gnt   = sel_host;
    assign core_stall = core_req & ~sel_core;
    assign core_rd    = sel_core & ~core_we;
    assign host_rd    = sel_host & ~host_we;

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            core_rvalid <= 1'b0;
            host_rvalid <= 1'b0;
            core_rdata  <= '0;
            host_rdata  <= '0;
        end else begin
            core_rvalid <= core_rd;
            host_rvalid <= host_rd;
            if (core_rd)
                core_rdata <= mem_rdata;
            if (host_rd)
                host_rdata <= mem_rdata;
        end
    end

endmodule
